// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with saturation on overflow.
// Optional leading-zero blank mask output enabled by defining BIN2BCD_BLANK_EN.
`timescale 1ns/1ps

module bin_to_bcd_seq #(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [BCD_W-1:0] BCD_SAT  = {DIGITS{4'h9}};

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BIN_W-1:0]     bin_w;
  logic [BCD_W-1:0]     bcd_w;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_w;

  logic                 accept;
  logic                 last_iter;
  logic [BCD_W-1:0]     bcd_adj;
  logic [BCD_W+BIN_W:0] shift_cat;
  logic                 shift_out;
  logic [BCD_W-1:0]     bcd_sh;
  logic [BIN_W-1:0]     bin_sh;
  logic                 ovf_res;
  logic [BCD_W-1:0]     res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SHIFT);
    accept    = (state == IDLE) && start;
    last_iter = (state == SHIFT) && (cnt == CNT_LAST);
  end

  // Add-3 correction happens before the shift so a digit >=5 carries correctly into its neighbour.
  always_comb begin
    bcd_adj = bcd_w;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_w[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd_w[4*d +: 4] + 4'd3;
      end
    end
  end

  assign shift_cat = {bcd_adj, bin_w, 1'b0};
  assign shift_out = shift_cat[BCD_W+BIN_W];
  assign bcd_sh    = shift_cat[BCD_W+BIN_W-1 : BIN_W];
  assign bin_sh    = shift_cat[BIN_W-1:0];

  // A 1 leaving the top digit means the value needs more digits than we have.
  assign ovf_res = ovf_w | shift_out;
  assign res     = ovf_res ? BCD_SAT : bcd_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_w <= '0;
      bcd_w <= '0;
      cnt   <= '0;
      ovf_w <= 1'b0;
    end else if (accept) begin
      bin_w <= bin_in;
      bcd_w <= '0;
      cnt   <= CNT_LOAD;
      ovf_w <= 1'b0;
    end else if (busy) begin
      bin_w <= bin_sh;
      bcd_w <= bcd_sh;
      cnt   <= cnt - CNT_LAST;
      ovf_w <= ovf_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      done <= last_iter;
      if (last_iter) begin
        bcd_out  <= res;
        overflow <= ovf_res;
      end
    end
  end

`ifdef BIN2BCD_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  logic [DIGITS-1:0] blank_nxt;

  // Digit i is blank when it and every digit above it are zero; the units digit always shows.
  always_comb begin
    logic hi_zero;
    blank_nxt = '0;
    hi_zero   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero      = hi_zero & (res[4*i +: 4] == 4'd0);
      blank_nxt[i] = hi_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= BLANK_RST;
    end else if (last_iter) begin
      blank <= blank_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 9-bit/3-digit and an 8-bit/2-digit instance share one clock.
// Fixed vectors, multi-cycle corner sequences and random values checked against an arithmetic model.
`timescale 1ns/1ps

module tb_bin_to_bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       start9 = 1'b0;
  logic [8:0] bin9 = '0;
  logic       busy9, done9, ovf9;
  logic [11:0] bcd9;

  logic       start8 = 1'b0;
  logic [7:0] bin8 = '0;
  logic       busy8, done8, ovf8;
  logic [7:0] bcd8;

`ifdef BIN2BCD_BLANK_EN
  logic [2:0] blank9;
  logic [1:0] blank8;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(9), .DIGITS(3)) dut9 (
    .clk(clk), .rst_n(rst_n), .start(start9), .bin_in(bin9),
    .busy(busy9), .done(done9), .bcd_out(bcd9), .overflow(ovf9)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank9)
`endif
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .bin_in(bin8),
    .busy(busy8), .done(done8), .bcd_out(bcd8), .overflow(ovf8)
`ifdef BIN2BCD_BLANK_EN
    , .blank(blank8)
`endif
  );

  typedef struct {
    bit          sel;
    int unsigned bin;
    logic [11:0] exp_bcd;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [63:0] getBcd(input bit sel);
    return sel ? 64'(bcd8) : 64'(bcd9);
  endfunction

  function automatic bit getDone(input bit sel);
    return sel ? done8 : done9;
  endfunction

  function automatic bit getBusy(input bit sel);
    return sel ? busy8 : busy9;
  endfunction

  function automatic bit getOvf(input bit sel);
    return sel ? ovf8 : ovf9;
  endfunction

`ifdef BIN2BCD_BLANK_EN
  function automatic logic [63:0] getBlank(input bit sel);
    return sel ? 64'(blank8) : 64'(blank9);
  endfunction
`endif

  // Reference: decimal digits by repeated division, saturating when the value needs more digits.
  function automatic logic [63:0] refBcd(input int unsigned v, input int digits, output bit ovf);
    int unsigned lim = 1;
    int unsigned x = v;
    logic [63:0] r = '0;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    ovf = (v >= lim);
    for (int i = 0; i < digits; i++) begin
      r = r | (64'(ovf ? 9 : (x % 10)) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] refBlank(input int unsigned v, input int digits, input bit ovf);
    int unsigned p = 1;
    logic [63:0] r = '0;
    for (int i = 1; i < digits; i++) begin
      p = p * 10;
      r[i] = !ovf && (v < p);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Returns edges (after the current one) until done is seen; 0 means it never came.
  task automatic waitDone(input bit sel, output int n);
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (getDone(sel)) begin
        n = c;
        break;
      end
    end
    if (n == 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input bit sel, input int unsigned v, output int lat);
    @(negedge clk);
    if (sel) begin
      start8 = 1'b1;
      bin8 = 8'(v);
    end else begin
      start9 = 1'b1;
      bin9 = 9'(v);
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start9 = 1'b0;
    checkOutput("busy_after_start", 64'(getBusy(sel)), 64'd1);
    waitDone(sel, lat);
  endtask

  task automatic checkConversion(input string tag, input bit sel, input int unsigned v);
    int lat;
    bit eovf;
    logic [63:0] ebcd;
    ebcd = refBcd(v, sel ? 2 : 3, eovf);
    applyStimulus(sel, v, lat);
    checkOutput({tag, "_latency"}, 64'(lat), sel ? 64'd8 : 64'd9);
    checkOutput({tag, "_bcd"}, getBcd(sel), ebcd);
    checkOutput({tag, "_ovf"}, 64'(getOvf(sel)), 64'(eovf));
`ifdef BIN2BCD_BLANK_EN
    checkOutput({tag, "_blank"}, getBlank(sel), refBlank(v, sel ? 2 : 3, eovf));
`endif
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int n;
    int cnt_done;
    int first_k;
    logic [63:0] seen_bcd;

    vecs[0]  = '{1'b0, 511, 12'h511, 1'b0};
    vecs[1]  = '{1'b0,   0, 12'h000, 1'b0};
    vecs[2]  = '{1'b0,   7, 12'h007, 1'b0};
    vecs[3]  = '{1'b0,   9, 12'h009, 1'b0};
    vecs[4]  = '{1'b0,  10, 12'h010, 1'b0};
    vecs[5]  = '{1'b0, 100, 12'h100, 1'b0};
    vecs[6]  = '{1'b0, 499, 12'h499, 1'b0};
    vecs[7]  = '{1'b1, 255, 12'h099, 1'b1};
    vecs[8]  = '{1'b1,  99, 12'h099, 1'b0};
    vecs[9]  = '{1'b1, 100, 12'h099, 1'b1};
    vecs[10] = '{1'b1,   0, 12'h000, 1'b0};
    vecs[11] = '{1'b1,  58, 12'h058, 1'b0};

    #12;
    checkOutput("reset_busy", 64'(busy9), 64'd0);
    checkOutput("reset_done", 64'(done9), 64'd0);
    checkOutput("reset_bcd9", 64'(bcd9), 64'd0);
    checkOutput("reset_ovf9", 64'(ovf9), 64'd0);
    checkOutput("reset_bcd8", 64'(bcd8), 64'd0);
`ifdef BIN2BCD_BLANK_EN
    checkOutput("reset_blank9", 64'(blank9), 64'h6);
    checkOutput("reset_blank8", 64'(blank8), 64'h2);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].bin, lat);
      checkOutput("vec_latency", 64'(lat), vecs[i].sel ? 64'd8 : 64'd9);
      checkOutput("vec_bcd", getBcd(vecs[i].sel), 64'(vecs[i].exp_bcd));
      checkOutput("vec_ovf", 64'(getOvf(vecs[i].sel)), 64'(vecs[i].exp_ovf));
      @(posedge clk);
      #1;
      checkOutput("vec_done_one_cycle", 64'(getDone(vecs[i].sel)), 64'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("hold_bcd8", 64'(bcd8), 64'h58);
    checkOutput("hold_bcd9", 64'(bcd9), 64'h499);

    // Back-to-back: start held high, second value presented in the done cycle.
    @(negedge clk);
    start9 = 1'b1;
    bin9 = 9'd0;
    @(posedge clk);
    #1;
    waitDone(1'b0, n);
    checkOutput("b2b_first_latency", 64'(n), 64'd9);
    checkOutput("b2b_first_bcd", 64'(bcd9), 64'h000);
`ifdef BIN2BCD_BLANK_EN
    checkOutput("b2b_first_blank", 64'(blank9), 64'h6);
`endif
    bin9 = 9'd7;
    @(posedge clk);
    #1;
    start9 = 1'b0;
    checkOutput("b2b_second_busy", 64'(busy9), 64'd1);
    waitDone(1'b0, n);
    checkOutput("b2b_gap", 64'(n + 1), 64'd10);
    checkOutput("b2b_second_bcd", 64'(bcd9), 64'h007);
`ifdef BIN2BCD_BLANK_EN
    checkOutput("b2b_second_blank", 64'(blank9), 64'h6);
`endif

    // Start and bin_in changes during a conversion must be ignored.
    @(negedge clk);
    start9 = 1'b1;
    bin9 = 9'd300;
    @(posedge clk);
    #1;
    start9 = 1'b0;
    bin9 = 9'd200;
    repeat (2) @(posedge clk);
    #1;
    start9 = 1'b1;
    bin9 = 9'd5;
    @(posedge clk);
    #1;
    start9 = 1'b0;
    cnt_done = 0;
    first_k = 0;
    seen_bcd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done9) begin
        cnt_done++;
        if (first_k == 0) begin
          first_k = k;
          seen_bcd = 64'(bcd9);
        end
      end
    end
    checkOutput("ignore_done_count", 64'(cnt_done), 64'd1);
    checkOutput("ignore_done_time", 64'(first_k), 64'd6);
    checkOutput("ignore_bcd", seen_bcd, 64'h300);

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    start9 = 1'b1;
    bin9 = 9'd421;
    @(posedge clk);
    #1;
    start9 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy9), 64'd0);
    checkOutput("midreset_bcd", 64'(bcd9), 64'd0);
    checkOutput("midreset_done", 64'(done9), 64'd0);
`ifdef BIN2BCD_BLANK_EN
    checkOutput("midreset_blank", 64'(blank9), 64'h6);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (done9) cnt_done++;
    end
    checkOutput("midreset_no_done", 64'(cnt_done), 64'd0);
    checkConversion("after_reset", 1'b0, 123);

    for (int r = 0; r < 40; r++) begin
      bit sel;
      int unsigned v;
      sel = 1'($urandom_range(0, 1));
      v = sel ? $urandom_range(0, 255) : $urandom_range(0, 511);
      checkConversion(sel ? "rand8" : "rand9", sel, v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
